// File: rtl/md5_pkg.sv
// ---------------------------------------------------------------------------
// md5_pkg
// Shared constants and the state type for the MD5 block packer.
//   MD5_BLOCK_W      : block width in bits
//   MD5_BLOCK_BYTES  : block width in bytes
//   MD5_PAD_LIMIT    : first byte position that no longer leaves room for the
//                      64-bit length field in the same block
//   MD5_PAD_BYTE     : the leading padding byte
//   packer_state_e   : packer FSM states; OUT_EXTRA only exists when the
//                      in-packer padding build option MD5_BLOCK_PACKER_PAD_EN
//                      is defined
// ---------------------------------------------------------------------------
package md5_pkg;

  localparam int          MD5_BLOCK_W     = 512;
  localparam int          MD5_BLOCK_BYTES = 64;
  localparam int          MD5_PAD_LIMIT   = 56;
  localparam logic [7:0]  MD5_PAD_BYTE    = 8'h80;

`ifdef MD5_BLOCK_PACKER_PAD_EN
  typedef enum logic [1:0] {
    FILL      = 2'd0,
    OUT       = 2'd1,
    OUT_EXTRA = 2'd2
  } packer_state_e;
`else
  typedef enum logic [1:0] {
    FILL      = 2'd0,
    OUT       = 2'd1
  } packer_state_e;
`endif

endpackage

// File: rtl/md5_block_packer.sv
// ---------------------------------------------------------------------------
// md5_block_packer
// Collects a byte stream into 512-bit MD5 blocks and hands them to the hash
// core with a valid/ready handshake.
//
// Build option: MD5_BLOCK_PACKER_PAD_EN
//   defined   : the packer appends the 0x80 byte, zero fill and the 64-bit
//               bit-length field, emitting an extra block when the tail does
//               not fit (state OUT_EXTRA).
//   undefined : the final block is the raw data zero-filled, always flagged
//               m_last=1; the downstream block does the padding using
//               msg_len_bits.
//
// Ports
//   clk, reset     : clock, asynchronous active-high reset
//   s_data         : message byte
//   s_valid        : byte beat valid
//   s_last         : final beat of the message
//   s_empty        : beat carries no byte (only meaningful with s_last)
//   s_ready        : packer accepts the beat
//   m_block        : output block, byte k at bits [8k+7:8k]
//   m_valid        : block valid
//   m_ready        : downstream accepts the block
//   m_last         : final block of the message
//   m_bytes        : message bytes carried in the block (0..64)
//   msg_len_bits   : total message length in bits (valid with m_last)
// Parameter
//   LEN_W          : bit-length counter width (16..64), zero-extended to 64
// ---------------------------------------------------------------------------
module md5_block_packer
  import md5_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [7:0]              s_data,
  input  logic                    s_valid,
  input  logic                    s_last,
  input  logic                    s_empty,
  output logic                    s_ready,
  output logic [MD5_BLOCK_W-1:0]  m_block,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic                    m_last,
  output logic [6:0]              m_bytes,
  output logic [63:0]             msg_len_bits
);

  // Zero-extend the internal length counter to the 64-bit length field.
  function automatic logic [63:0] len_to64(input logic [LEN_W-1:0] v);
    logic [63:0] r;
    r = 64'd0;
    r[LEN_W-1:0] = v;
    return r;
  endfunction

  // Keep the first cnt bytes of data and zero everything after them, so
  // stale buffer contents from an earlier block never leak out.
  function automatic logic [MD5_BLOCK_W-1:0] mask_block(
    input logic [MD5_BLOCK_W-1:0] data,
    input logic [6:0]             cnt
  );
    logic [MD5_BLOCK_W-1:0] r;
    r = {MD5_BLOCK_W{1'b0}};
    for (int k = 0; k < MD5_BLOCK_BYTES; k++) begin
      if (k < int'(cnt)) begin
        r[8*k +: 8] = data[8*k +: 8];
      end else begin
        r[8*k +: 8] = 8'h00;
      end
    end
    return r;
  endfunction

`ifdef MD5_BLOCK_PACKER_PAD_EN
  // Final data block: 0x80 right after the data when there is room, and the
  // length field only when the 0x80 byte landed below the length slot.
  function automatic logic [MD5_BLOCK_W-1:0] pad_final(
    input logic [MD5_BLOCK_W-1:0] data,
    input logic [6:0]             cnt,
    input logic [63:0]            len
  );
    logic [MD5_BLOCK_W-1:0] r;
    r = mask_block(data, cnt);
    if (cnt < 7'(MD5_BLOCK_BYTES)) begin
      r[{cnt[5:0], 3'b000} +: 8] = MD5_PAD_BYTE;
    end
    if (cnt < 7'(MD5_PAD_LIMIT)) begin
      r[MD5_BLOCK_W-1 -: 64] = len;
    end
    return r;
  endfunction

  // Overflow block: carries the length, plus the 0x80 byte when the data
  // block was completely full and had no room for it.
  function automatic logic [MD5_BLOCK_W-1:0] extra_block(
    input logic [6:0]  cnt,
    input logic [63:0] len
  );
    logic [MD5_BLOCK_W-1:0] r;
    r = {MD5_BLOCK_W{1'b0}};
    if (cnt == 7'(MD5_BLOCK_BYTES)) begin
      r[7:0] = MD5_PAD_BYTE;
    end
    r[MD5_BLOCK_W-1 -: 64] = len;
    return r;
  endfunction
`endif

  packer_state_e            state_r, state_nxt_s;
  logic [MD5_BLOCK_W-1:0]   buf_r, buf_nxt_s, buf_add_s;
  logic [6:0]               cnt_r, cnt_nxt_s, cnt_add_s;
  logic [LEN_W-1:0]         len_r, len_nxt_s, len_add_s;
  logic                     extra_r, extra_nxt_s;
  logic                     acc_s, wr_s, done_s, fin_s;

  logic [MD5_BLOCK_W-1:0]   m_block_r, blk_nxt_s;
  logic                     m_valid_r, valid_nxt_s;
  logic                     m_last_r, last_nxt_s;
  logic [6:0]               m_bytes_r, bytes_nxt_s;
  logic [63:0]              msg_len_r, len_out_nxt_s;
  logic                     s_ready_r, ready_nxt_s;

  assign s_ready      = s_ready_r;
  assign m_block      = m_block_r;
  assign m_valid      = m_valid_r;
  assign m_last       = m_last_r;
  assign m_bytes      = m_bytes_r;
  assign msg_len_bits = msg_len_r;

  // Accepted-beat view: buffer, count and length as they would be after
  // taking the beat currently on the input.
  always_comb begin
    acc_s     = s_valid && s_ready_r && (state_r == FILL);
    wr_s      = acc_s && !s_empty;
    buf_add_s = buf_r;
    cnt_add_s = cnt_r;
    len_add_s = len_r;
    if (wr_s) begin
      buf_add_s[{cnt_r[5:0], 3'b000} +: 8] = s_data;
      cnt_add_s = cnt_r + 7'd1;
      len_add_s = len_r + LEN_W'(8);
    end else begin
      buf_add_s = buf_r;
      cnt_add_s = cnt_r;
      len_add_s = len_r;
    end
    fin_s  = acc_s && s_last;
    done_s = acc_s && (s_last || (cnt_add_s == 7'(MD5_BLOCK_BYTES)));
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= FILL;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      FILL: begin
        if (done_s) begin
          state_nxt_s = OUT;
        end else begin
          state_nxt_s = FILL;
        end
      end
      OUT: begin
        if (m_ready) begin
`ifdef MD5_BLOCK_PACKER_PAD_EN
          state_nxt_s = extra_r ? OUT_EXTRA : FILL;
`else
          state_nxt_s = FILL;
`endif
        end else begin
          state_nxt_s = OUT;
        end
      end
`ifdef MD5_BLOCK_PACKER_PAD_EN
      OUT_EXTRA: begin
        if (m_ready) begin
          state_nxt_s = FILL;
        end else begin
          state_nxt_s = OUT_EXTRA;
        end
      end
`endif
      default: state_nxt_s = FILL;
    endcase
  end

  // FSM output logic: next values of the datapath and registered outputs.
  always_comb begin
    buf_nxt_s     = buf_r;
    cnt_nxt_s     = cnt_r;
    len_nxt_s     = len_r;
    extra_nxt_s   = extra_r;
    blk_nxt_s     = m_block_r;
    valid_nxt_s   = m_valid_r;
    last_nxt_s    = m_last_r;
    bytes_nxt_s   = m_bytes_r;
    len_out_nxt_s = msg_len_r;
    ready_nxt_s   = s_ready_r;
    case (state_r)
      FILL: begin
        valid_nxt_s = 1'b0;
        ready_nxt_s = 1'b1;
        if (acc_s) begin
          buf_nxt_s = buf_add_s;
          cnt_nxt_s = cnt_add_s;
          len_nxt_s = len_add_s;
        end else begin
          buf_nxt_s = buf_r;
        end
        if (done_s) begin
          valid_nxt_s   = 1'b1;
          ready_nxt_s   = 1'b0;
          bytes_nxt_s   = cnt_add_s;
          len_out_nxt_s = len_to64(len_add_s);
`ifdef MD5_BLOCK_PACKER_PAD_EN
          if (fin_s) begin
            blk_nxt_s   = pad_final(buf_add_s, cnt_add_s, len_to64(len_add_s));
            // Tail at byte 56 or later cannot hold the length field.
            last_nxt_s  = (cnt_add_s < 7'(MD5_PAD_LIMIT));
            extra_nxt_s = !(cnt_add_s < 7'(MD5_PAD_LIMIT));
          end else begin
            blk_nxt_s   = buf_add_s;
            last_nxt_s  = 1'b0;
            extra_nxt_s = 1'b0;
          end
`else
          blk_nxt_s   = mask_block(buf_add_s, cnt_add_s);
          last_nxt_s  = fin_s;
          extra_nxt_s = 1'b0;
`endif
        end else begin
          blk_nxt_s = m_block_r;
        end
      end
      OUT: begin
        if (m_ready && extra_r) begin
`ifdef MD5_BLOCK_PACKER_PAD_EN
          blk_nxt_s   = extra_block(cnt_r, msg_len_r);
`else
          blk_nxt_s   = m_block_r;
`endif
          bytes_nxt_s = 7'd0;
          last_nxt_s  = 1'b1;
          valid_nxt_s = 1'b1;
          extra_nxt_s = 1'b0;
        end else if (m_ready) begin
          valid_nxt_s = 1'b0;
          ready_nxt_s = 1'b1;
          cnt_nxt_s   = 7'd0;
          last_nxt_s  = 1'b0;
          // Length only restarts once the whole message has been handed off.
          if (m_last_r) begin
            len_nxt_s = {LEN_W{1'b0}};
          end else begin
            len_nxt_s = len_r;
          end
        end else begin
          valid_nxt_s = 1'b1;
        end
      end
`ifdef MD5_BLOCK_PACKER_PAD_EN
      OUT_EXTRA: begin
        if (m_ready) begin
          valid_nxt_s = 1'b0;
          ready_nxt_s = 1'b1;
          cnt_nxt_s   = 7'd0;
          len_nxt_s   = {LEN_W{1'b0}};
          last_nxt_s  = 1'b0;
        end else begin
          valid_nxt_s = 1'b1;
        end
      end
`endif
      default: begin
        valid_nxt_s = 1'b0;
        ready_nxt_s = 1'b1;
        cnt_nxt_s   = 7'd0;
        len_nxt_s   = {LEN_W{1'b0}};
        extra_nxt_s = 1'b0;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_r     <= {MD5_BLOCK_W{1'b0}};
      cnt_r     <= 7'd0;
      len_r     <= {LEN_W{1'b0}};
      extra_r   <= 1'b0;
      m_block_r <= {MD5_BLOCK_W{1'b0}};
      m_valid_r <= 1'b0;
      m_last_r  <= 1'b0;
      m_bytes_r <= 7'd0;
      msg_len_r <= 64'd0;
      s_ready_r <= 1'b0;
    end else begin
      buf_r     <= buf_nxt_s;
      cnt_r     <= cnt_nxt_s;
      len_r     <= len_nxt_s;
      extra_r   <= extra_nxt_s;
      m_block_r <= blk_nxt_s;
      m_valid_r <= valid_nxt_s;
      m_last_r  <= last_nxt_s;
      m_bytes_r <= bytes_nxt_s;
      msg_len_r <= len_out_nxt_s;
      s_ready_r <= ready_nxt_s;
    end
  end

endmodule

// File: tb/tb_md5_block_packer.sv
// ---------------------------------------------------------------------------
// tb_md5_block_packer
// Directed self-checking bench for md5_block_packer. Expected blocks are
// built by hand per scenario; padding expectations follow the build option
// MD5_BLOCK_PACKER_PAD_EN.
// ---------------------------------------------------------------------------
module tb_md5_block_packer;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   s_data = 8'h00;
  logic         s_valid = 1'b0;
  logic         s_last = 1'b0;
  logic         s_empty = 1'b0;
  logic         s_ready;
  logic [511:0] m_block;
  logic         m_valid;
  logic         m_ready = 1'b0;
  logic         m_last;
  logic [6:0]   m_bytes;
  logic [63:0]  msg_len_bits;

  int n_cmp = 0;
  int n_err = 0;

  md5_block_packer #(.LEN_W(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_last       (s_last),
    .s_empty      (s_empty),
    .s_ready      (s_ready),
    .m_block      (m_block),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_last       (m_last),
    .m_bytes      (m_bytes),
    .msg_len_bits (msg_len_bits)
  );

  always #5 clk = ~clk;

  // Present one beat and hold it until the packer takes it (bounded).
  task automatic send_beat(input logic [7:0] d, input logic last, input logic empty);
    int n;
    s_data = d; s_last = last; s_empty = empty; s_valid = 1'b1;
    n = 0;
    while (!s_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0; s_empty = 1'b0; s_data = 8'h00;
  endtask

  // Wait (bounded) for a block, capture it, then complete the handshake.
  task automatic get_block(output logic [511:0] blk, output logic [6:0] bytes,
                           output logic last, output logic [63:0] len, output bit to);
    int n;
    n = 0; to = 1'b0;
    while (!m_valid && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!m_valid) begin
      to = 1'b1; blk = 512'd0; bytes = 7'd0; last = 1'b0; len = 64'd0;
    end else begin
      blk = m_block; bytes = m_bytes; last = m_last; len = msg_len_bits;
      m_ready = 1'b1;
      @(posedge clk); #1;
      m_ready = 1'b0;
    end
  endtask

  task automatic send_abc();
    send_beat(8'h61, 1'b0, 1'b0);
    send_beat(8'h62, 1'b0, 1'b0);
    send_beat(8'h63, 1'b1, 1'b0);
  endtask

  function automatic logic [511:0] exp_abc();
    logic [511:0] e;
    e = 512'd0;
    e[7:0] = 8'h61; e[15:8] = 8'h62; e[23:16] = 8'h63;
`ifdef MD5_BLOCK_PACKER_PAD_EN
    e[31:24] = 8'h80;
    e[511:448] = 64'd24;
`endif
    return e;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    #3;
    n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL reset_s_ready got=%b exp=0", s_ready); end
    n_cmp++; if (m_valid !== 1'b0) begin n_err++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    n_cmp++; if (m_block !== 512'd0) begin n_err++; $display("FAIL reset_m_block got=%h exp=0", m_block); end
    n_cmp++; if ({m_last, m_bytes, msg_len_bits} !== 72'd0) begin
      n_err++; $display("FAIL reset_misc got last=%b bytes=%0d len=%0d exp=0", m_last, m_bytes, msg_len_bits);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++; if (s_ready !== 1'b0) begin n_err++; $display("FAIL ready_before_edge got=%b exp=0", s_ready); end
    @(posedge clk); #1;
    n_cmp++; if (s_ready !== 1'b1) begin n_err++; $display("FAIL ready_after_edge got=%b exp=1", s_ready); end
  endtask

  task automatic test_abc();
    logic [511:0] b; logic [6:0] nb; logic l; logic [63:0] ln; bit to;
    send_abc();
    get_block(b, nb, l, ln, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL abc_timeout got=%b exp=0", to); end
    n_cmp++; if (b !== exp_abc()) begin n_err++; $display("FAIL abc_block got=%h exp=%h", b, exp_abc()); end
    n_cmp++; if ({nb, l, ln} !== {7'd3, 1'b1, 64'd24}) begin
      n_err++; $display("FAIL abc_meta got bytes=%0d last=%b len=%0d exp 3/1/24", nb, l, ln);
    end
  endtask

  task automatic test_empty();
    logic [511:0] b, e; logic [6:0] nb; logic l; logic [63:0] ln; bit to;
    e = 512'd0;
`ifdef MD5_BLOCK_PACKER_PAD_EN
    e[7:0] = 8'h80;
`endif
    send_beat(8'h00, 1'b1, 1'b1);
    get_block(b, nb, l, ln, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL empty_timeout got=%b exp=0", to); end
    n_cmp++; if (b !== e) begin n_err++; $display("FAIL empty_block got=%h exp=%h", b, e); end
    n_cmp++; if ({nb, l, ln} !== {7'd0, 1'b1, 64'd0}) begin
      n_err++; $display("FAIL empty_meta got bytes=%0d last=%b len=%0d exp 0/1/0", nb, l, ln);
    end
  endtask

  task automatic test_len56();
    logic [511:0] b, e; logic [6:0] nb; logic l; logic [63:0] ln; bit to;
    e = 512'd0;
    for (int k = 0; k < 56; k++) begin
      e[8*k +: 8] = 8'h41;
      send_beat(8'h41, (k == 55), 1'b0);
    end
    get_block(b, nb, l, ln, to);
`ifdef MD5_BLOCK_PACKER_PAD_EN
    e[455:448] = 8'h80;
    n_cmp++; if (b !== e || to) begin n_err++; $display("FAIL len56_blk1 got=%h exp=%h", b, e); end
    n_cmp++; if ({nb, l} !== {7'd56, 1'b0}) begin n_err++; $display("FAIL len56_meta1 got bytes=%0d last=%b exp 56/0", nb, l); end
    get_block(b, nb, l, ln, to);
    e = 512'd0; e[511:448] = 64'd448;
    n_cmp++; if (b !== e || to) begin n_err++; $display("FAIL len56_blk2 got=%h exp=%h", b, e); end
    n_cmp++; if ({nb, l, ln} !== {7'd0, 1'b1, 64'd448}) begin
      n_err++; $display("FAIL len56_meta2 got bytes=%0d last=%b len=%0d exp 0/1/448", nb, l, ln);
    end
`else
    n_cmp++; if (b !== e || to) begin n_err++; $display("FAIL len56_blk got=%h exp=%h", b, e); end
    n_cmp++; if ({nb, l, ln} !== {7'd56, 1'b1, 64'd448}) begin
      n_err++; $display("FAIL len56_meta got bytes=%0d last=%b len=%0d exp 56/1/448", nb, l, ln);
    end
`endif
    @(posedge clk); #1;
    n_cmp++; if ({m_valid, s_ready} !== 2'b01) begin
      n_err++; $display("FAIL len56_idle got valid=%b ready=%b exp 0/1", m_valid, s_ready);
    end
  endtask

  // 64 bytes; either s_last on byte 64, or a trailing empty last beat.
  task automatic test_len64(input bit empty_tail);
    logic [511:0] b, e; logic [6:0] nb; logic l; logic [63:0] ln; bit to;
    e = 512'd0;
    for (int k = 0; k < 64; k++) begin
      e[8*k +: 8] = 8'(k + 3);
      send_beat(8'(k + 3), (k == 63) && !empty_tail, 1'b0);
    end
    if (empty_tail) begin
      get_block(b, nb, l, ln, to);
      n_cmp++; if (b !== e || to) begin n_err++; $display("FAIL mult_blk1 got=%h exp=%h", b, e); end
      n_cmp++; if ({nb, l} !== {7'd64, 1'b0}) begin n_err++; $display("FAIL mult_meta1 got bytes=%0d last=%b exp 64/0", nb, l); end
      send_beat(8'h00, 1'b1, 1'b1);
    end else begin
      get_block(b, nb, l, ln, to);
      n_cmp++; if (b !== e || to) begin n_err++; $display("FAIL len64_blk1 got=%h exp=%h", b, e); end
`ifdef MD5_BLOCK_PACKER_PAD_EN
      n_cmp++; if ({nb, l} !== {7'd64, 1'b0}) begin n_err++; $display("FAIL len64_meta1 got bytes=%0d last=%b exp 64/0", nb, l); end
`else
      n_cmp++; if ({nb, l, ln} !== {7'd64, 1'b1, 64'd512}) begin
        n_err++; $display("FAIL len64_meta1 got bytes=%0d last=%b len=%0d exp 64/1/512", nb, l, ln);
      end
`endif
    end
`ifdef MD5_BLOCK_PACKER_PAD_EN
    get_block(b, nb, l, ln, to);
    e = 512'd0; e[7:0] = 8'h80; e[511:448] = 64'd512;
    n_cmp++; if (b !== e || to) begin n_err++; $display("FAIL len64_tail_blk got=%h exp=%h", b, e); end
    n_cmp++; if ({nb, l, ln} !== {7'd0, 1'b1, 64'd512}) begin
      n_err++; $display("FAIL len64_tail_meta got bytes=%0d last=%b len=%0d exp 0/1/512", nb, l, ln);
    end
`else
    if (empty_tail) begin
      get_block(b, nb, l, ln, to);
      n_cmp++; if (b !== 512'd0 || to) begin n_err++; $display("FAIL mult_blk2 got=%h exp=0", b); end
      n_cmp++; if ({nb, l, ln} !== {7'd0, 1'b1, 64'd512}) begin
        n_err++; $display("FAIL mult_meta2 got bytes=%0d last=%b len=%0d exp 0/1/512", nb, l, ln);
      end
    end
`endif
    @(posedge clk); #1;
    n_cmp++; if ({m_valid, s_ready} !== 2'b01) begin
      n_err++; $display("FAIL len64_idle got valid=%b ready=%b exp 0/1", m_valid, s_ready);
    end
  endtask

  task automatic test_stall();
    logic [511:0] b; logic [6:0] nb; logic l; logic [63:0] ln; bit to;
    int n;
    send_abc();
    n = 0;
    while (!m_valid && n < 200) begin @(posedge clk); #1; n++; end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_cmp++; if ({m_valid, s_ready} !== 2'b10 || m_block !== exp_abc() || m_bytes !== 7'd3) begin
        n_err++; $display("FAIL stall_cycle%0d got valid=%b ready=%b bytes=%0d blk=%h", c, m_valid, s_ready, m_bytes, m_block);
      end
    end
    get_block(b, nb, l, ln, to);
    n_cmp++; if (b !== exp_abc() || {nb, l, ln} !== {7'd3, 1'b1, 64'd24} || to) begin
      n_err++; $display("FAIL stall_release got bytes=%0d last=%b len=%0d blk=%h", nb, l, ln, b);
    end
  endtask

  task automatic test_reset_mid();
    logic [511:0] b; logic [6:0] nb; logic l; logic [63:0] ln; bit to;
    int n;
    for (int k = 0; k < 20; k++) send_beat(8'h55, 1'b0, 1'b0);
    reset = 1'b1; #2;
    n_cmp++; if ({s_ready, m_valid} !== 2'b00) begin n_err++; $display("FAIL rstmid_fill got ready=%b valid=%b exp 0/0", s_ready, m_valid); end
    @(posedge clk); #1; reset = 1'b0;
    send_abc();
    get_block(b, nb, l, ln, to);
    n_cmp++; if (b !== exp_abc() || {nb, l, ln} !== {7'd3, 1'b1, 64'd24} || to) begin
      n_err++; $display("FAIL rstmid_abc got bytes=%0d last=%b len=%0d blk=%h", nb, l, ln, b);
    end
    send_abc();
    n = 0;
    while (!m_valid && n < 200) begin @(posedge clk); #1; n++; end
    reset = 1'b1; #2;
    n_cmp++; if ({m_valid, m_last, s_ready} !== 3'b000 || m_block !== 512'd0 || msg_len_bits !== 64'd0) begin
      n_err++; $display("FAIL rstmid_out got valid=%b last=%b ready=%b len=%0d", m_valid, m_last, s_ready, msg_len_bits);
    end
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_abc();
    test_empty();
    test_len56();
    test_len64(1'b0);
    test_len64(1'b1);
    test_stall();
    test_reset_mid();
    test_abc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
